axis2adi_conv: RTL

AXI-Stream slave to ADI DAC sample interface; the transmit-path counterpart of the ADC capture converter. Accepts DMA words on S_AXIS, buffers them in a small FIFO and hands one word to the DAC core per read strobe. Software controls start, trigger-armed start and byte length through ctrl/num_bytes and reads progress on stat. Sits between the AXI DMA MM2S stream and the DAC core.

---
 rtl/axis2adi_pkg.sv | 21 ++
 rtl/axis2adi_fifo.sv | 60 ++++++
 rtl/axis2adi_conv.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/axis2adi_pkg.sv
// Shared definitions for the AXI-Stream to ADI DAC sample converter.
package axis2adi_pkg;

  // Converter state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Software command values on ctrl
  localparam logic [31:0] CTRL_STOP  = 32'd0;
  localparam logic [31:0] CTRL_START = 32'd1;
  localparam logic [31:0] CTRL_TRIG  = 32'd2;

  // Bit positions inside stat
  localparam int unsigned STAT_ARMED   = 0;
  localparam int unsigned STAT_RUNNING = 1;
  localparam int unsigned STAT_DONE    = 2;
  localparam int unsigned STAT_UNF     = 3;

endpackage

// File: rtl/axis2adi_fifo.sv
// Small synchronous FIFO with registered read data; no fall-through.
module axis2adi_fifo #(
  parameter int unsigned W          = 64,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full   = (r_count == LP_FULL);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Read data register; a pop in the same cycle as a flush still delivers its word
  always_ff @(posedge clk) begin
    if (!rst_n)     dout <= '0;
    else if (w_pop) dout <= r_mem[r_rptr];
  end

  // Pointer and occupancy tracking, flush discards all contents
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis2adi_conv.sv
// AXI-Stream slave feeding the ADI DAC sample interface through a small FIFO.
module axis2adi_conv
  import axis2adi_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_NUM_BYTES = 8,
  parameter int unsigned C_FIFO_DEPTH_LOG2        = 2
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic                                  S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_NUM_BYTES*8-1:0] S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
  input  logic                                  S_AXIS_TLAST,
  output logic                                  S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_NUM_BYTES*8-1:0] ddata,
  output logic                                  dvalid,
  input  logic                                  drd,
  output logic                                  dunf,
  input  logic [31:0]                           ctrl,
  input  logic [31:0]                           num_bytes,
  output logic [31:0]                           stat,
  input  logic                                  trig
);

  localparam int unsigned W       = C_S_AXIS_TDATA_NUM_BYTES * 8;
  localparam logic [32:0] LP_STEP = 33'(C_S_AXIS_TDATA_NUM_BYTES);

  logic [1:0]  r_state;
  logic [31:0] r_len;
  logic [31:0] r_cnt;
  logic        r_last_in;
  logic        r_unf_sticky;
  logic        r_trig_d;
  logic        r_dvalid;
  logic        r_dunf;

  logic        w_full;
  logic        w_empty;
  logic        w_run;
  logic        w_stop;
  logic        w_push;
  logic        w_pop;
  logic        w_unf;
  logic        w_final;
  logic        w_trig_rise;
  logic        w_unused_tstrb;

  // All strobe bytes are treated as valid
  assign w_unused_tstrb = ^S_AXIS_TSTRB;

  assign w_run         = (r_state == RUN);
  assign w_stop        = (ctrl == CTRL_STOP);
  assign S_AXIS_TREADY = w_run & ~w_full & ~r_last_in;
  assign w_push        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_pop         = drd & w_run & ~w_empty;
  assign w_unf         = drd & w_run & w_empty & ~r_last_in;
  assign w_trig_rise   = trig & ~r_trig_d;
  // 33-bit sum keeps the length comparison exact near the top of the 32-bit range
  assign w_final       = S_AXIS_TLAST |
                         ((r_len != '0) && (({1'b0, r_cnt} + LP_STEP) >= {1'b0, r_len}));

  axis2adi_fifo #(
    .W          (W),
    .DEPTH_LOG2 (C_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (AXIS_ACLK),
    .rst_n (AXIS_ARESETN),
    .flush (w_stop),
    .push  (w_push),
    .pop   (w_pop),
    .din   (S_AXIS_TDATA),
    .dout  (ddata),
    .full  (w_full),
    .empty (w_empty)
  );

  // Control state machine; a stop command overrides every state
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      r_state <= IDLE;
      r_len   <= '0;
    end else if (w_stop) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (ctrl == CTRL_START) begin
            r_state <= RUN;
            r_len   <= num_bytes;
          end else if (ctrl == CTRL_TRIG) begin
            r_state <= ARMED;
            r_len   <= num_bytes;
          end
        end
        ARMED:   if (w_trig_rise) r_state <= RUN;
        RUN:     if (r_last_in && w_empty) r_state <= DONE;
        default: r_state <= r_state;
      endcase
    end
  end

  // Transfer bookkeeping: byte count, final-word flag, sticky underflow
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN || w_stop) begin
      r_cnt        <= '0;
      r_last_in    <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_cnt <= r_cnt + 32'(C_S_AXIS_TDATA_NUM_BYTES);
        if (w_final) r_last_in <= 1'b1;
      end
      if (w_unf) r_unf_sticky <= 1'b1;
    end
  end

  // Per-read output pulses and trigger edge history
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      r_dvalid <= 1'b0;
      r_dunf   <= 1'b0;
      r_trig_d <= 1'b0;
    end else begin
      r_dvalid <= w_pop;
      r_dunf   <= w_unf;
      r_trig_d <= trig;
    end
  end

  assign dvalid = r_dvalid;
  assign dunf   = r_dunf;

  // Status word assembled from registered state
  always_comb begin
    stat               = '0;
    stat[STAT_ARMED]   = (r_state == ARMED);
    stat[STAT_RUNNING] = w_run;
    stat[STAT_DONE]    = (r_state == DONE);
    stat[STAT_UNF]     = r_unf_sticky;
  end

endmodule
